job_issuer: RTL and testbench

//  Initiator side of the start/done handshake used by our iterative compute units.

---
 rtl/job_issuer.sv | 182 ++++++++++++++++++
 tb/tb_job_issuer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_issuer.sv
// job_issuer: buffers host operand pairs in a FIFO and issues them one at a time to an
// iterative compute unit over a level start/done handshake, returning results on valid/ready.
// Optional feature macro: JOB_TIMEOUT_EN aborts a job after TIMEOUT RUN cycles without done.
module job_issuer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             unit_start,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Reject configurations the pointer arithmetic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("job_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic             run_first_q;
  logic             timeout_hit;

  logic             unit_start_d, out_valid_d, out_err_d, in_ready_d, busy_d;
  logic [WIDTH-1:0] unit_a_d, unit_b_d, out_data_d;
  logic [CNT_W-1:0] jobs_done_d;

  assign push = in_valid && in_ready;

`ifdef JOB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] run_cnt_q;

  // Counts RUN cycles; zero on the first RUN cycle of every job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else if (state_q == RUN) begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end else begin
      run_cnt_q <= '0;
    end
  end

  assign timeout_hit = (run_cnt_q == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Operand storage; no reset needed since entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr_q] <= in_a;
      fifo_b[wr_ptr_q] <= in_b;
    end
  end

  // Next-state and next-output logic for the issue FSM and FIFO occupancy.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    unit_start_d = unit_start;
    unit_a_d     = unit_a;
    unit_b_d     = unit_b;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_err_d    = out_err;
    jobs_done_d  = jobs_done;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          unit_a_d     = fifo_a[rd_ptr_q];
          unit_b_d     = fifo_b[rd_ptr_q];
          unit_start_d = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        // First RUN cycle is the unit's load cycle, so done is not trusted there.
        if (!run_first_q && unit_done) begin
          out_data_d   = unit_result;
          out_err_d    = 1'b0;
          out_valid_d  = 1'b1;
          unit_start_d = 1'b0;
          state_d      = HOLD;
        end else if (timeout_hit) begin
          out_data_d   = '0;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
          unit_start_d = 1'b0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          jobs_done_d = jobs_done + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    in_ready_d = (count_d != CW'(DEPTH));
    busy_d     = (state_d != IDLE) || (count_d != '0);
  end

  // State, pointers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      run_first_q <= 1'b0;
      unit_start  <= 1'b0;
      unit_a      <= '0;
      unit_b      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      jobs_done   <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      run_first_q <= (state_q == IDLE);
      unit_start  <= unit_start_d;
      unit_a      <= unit_a_d;
      unit_b      <= unit_b_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_err     <= out_err_d;
      jobs_done   <= jobs_done_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_job_issuer.sv
// tb_job_issuer: drives job_issuer with a GCD unit model; results checked through a scoreboard.
module tb_job_issuer;

  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk, rst_n;
  logic             in_valid, in_ready;
  logic [W-1:0]     in_a, in_b;
  logic             unit_start, unit_done;
  logic [W-1:0]     unit_a, unit_b, unit_result;
  logic             out_valid, out_ready, out_err, busy;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] jobs_done;

  job_issuer #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compute-unit model: GCD, done after 'lat' RUN cycles unless stalled.
  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  int         lat;
  logic       stall, spurious;
  logic [7:0] run_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                run_cyc <= 8'd0;
    else if (!unit_start)      run_cyc <= 8'd0;
    else if (run_cyc != 8'hff) run_cyc <= run_cyc + 8'd1;
  end

  assign unit_done   = spurious || (unit_start && !stall && (int'(run_cyc) >= lat - 1));
  assign unit_result = gcd8(unit_a, unit_b);

  // Scoreboard: expectation queued on accepted push, compared on result handshake.
  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] cur_data;
  logic       cur_err;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back('{cur_data, cur_err});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: result %0d with nothing expected", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_err", 32'(out_err), 32'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] e, input logic er);
    int n;
    in_valid = 1'b1;
    in_a = a; in_b = b; cur_data = e; cur_err = er;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!unit_start && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("start_timeout", 32'(unit_start), 32'd1);
  endtask

  task automatic run_len(output int n);
    n = 0;
    while (unit_start && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    check("drained", 32'(!busy && sb.size() == 0), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [7:0] exp;
    int         exp_run;
  } vec_t;
  vec_t       vecs[8];
  logic [7:0] t2a[6], t2b[6], t2e[6];
  int         exp_jobs, n;

  initial begin
    vecs[0] = '{8'd12,  8'd8,  5, 8'd4,  5};
    vecs[1] = '{8'd9,   8'd6,  1, 8'd3,  2};
    vecs[2] = '{8'd17,  8'd5,  3, 8'd1,  3};
    vecs[3] = '{8'd0,   8'd7,  2, 8'd7,  2};
    vecs[4] = '{8'd255, 8'd85, 4, 8'd85, 4};
    vecs[5] = '{8'd100, 8'd75, 2, 8'd25, 2};
    vecs[6] = '{8'd7,   8'd7,  6, 8'd7,  6};
    vecs[7] = '{8'd36,  8'd24, 3, 8'd12, 3};
    t2a = '{8'd12, 8'd9, 8'd10, 8'd21, 8'd5, 8'd50};
    t2b = '{8'd8,  8'd6, 8'd4,  8'd14, 8'd3, 8'd25};
    t2e = '{8'd4,  8'd3, 8'd2,  8'd7,  8'd1, 8'd25};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    stall = 1'b0; spurious = 1'b0; lat = 3; cur_data = '0; cur_err = 1'b0;
    exp_jobs = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_unit_start", 32'(unit_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_unit_a", 32'(unit_a), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Done while idle must be ignored.
    spurious = 1'b1;
    tick(); tick();
    check("idle_spurious_valid", 32'(out_valid), 32'd0);
    check("idle_spurious_busy", 32'(busy), 32'd0);
    spurious = 1'b0;

    // Single job, exact cycle timing.
    lat = 5;
    push_pair(8'd12, 8'd8, 8'd4, 1'b0);
    check("t1_start_after_push", 32'(unit_start), 32'd0);
    tick();
    check("t1_start_2cyc", 32'(unit_start), 32'd1);
    check("t1_unit_a", 32'(unit_a), 32'd12);
    check("t1_unit_b", 32'(unit_b), 32'd8);
    repeat (4) tick();
    check("t1_no_early_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'd4);
    check("t1_err", 32'(out_err), 32'd0);
    check("t1_start_low", 32'(unit_start), 32'd0);
    tick();
    exp_jobs = 1;
    check("t1_jobs_done", 32'(jobs_done), 32'(exp_jobs));
    check("t1_valid_cleared", 32'(out_valid), 32'd0);
    check("t1_start_still_low", 32'(unit_start), 32'd0);

    // Table-driven single jobs with varying unit latency.
    for (int i = 0; i < 8; i++) begin
      lat = vecs[i].lat;
      push_pair(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
      wait_start();
      run_len(n);
      check("vec_run_len", 32'(n), 32'(vecs[i].exp_run));
      wait_drain();
      exp_jobs++;
      check("vec_jobs_done", 32'(jobs_done), 32'(exp_jobs));
    end

    // Stalled unit: 1 running + DEPTH queued, sixth push refused; order preserved.
    stall = 1'b1; lat = 2;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = t2a[i]; in_b = t2b[i]; cur_data = t2e[i]; cur_err = 1'b0;
      check("t2_in_ready", 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t2_stalled_running", 32'(unit_start), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    wait_drain();
    exp_jobs += 5;
    check("t2_jobs_done", 32'(jobs_done), 32'(exp_jobs));

    // Host back-pressure in HOLD: output stable, next job waits for handshake.
    out_ready = 1'b0; lat = 3;
    push_pair(8'd18, 8'd12, 8'd6, 1'b0);
    push_pair(8'd10, 8'd4, 8'd2, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    spurious = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("t3_valid_held", 32'(out_valid), 32'd1);
      check("t3_data_held", 32'(out_data), 32'd6);
      check("t3_start_low", 32'(unit_start), 32'd0);
      if (k == 4) spurious = 1'b0;
      tick();
    end
    spurious = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_valid_dropped", 32'(out_valid), 32'd0);
    check("t3_start_idle", 32'(unit_start), 32'd0);
    tick();
    check("t3_next_started", 32'(unit_start), 32'd1);
    wait_drain();
    exp_jobs += 2;
    check("t3_jobs_done", 32'(jobs_done), 32'(exp_jobs));

`ifdef JOB_TIMEOUT_EN
    // Timeout abort, then a normal job.
    stall = 1'b1;
    push_pair(8'd33, 8'd11, 8'd0, 1'b1);
    wait_start();
    run_len(n);
    check("t5_timeout_len", 32'(n), 32'(TIMEOUT));
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_err", 32'(out_err), 32'd1);
    check("t5_data", 32'(out_data), 32'd0);
    stall = 1'b0; lat = 3;
    wait_drain();
    push_pair(8'd33, 8'd11, 8'd11, 1'b0);
    wait_drain();
    exp_jobs += 2;
    check("t5_jobs_done", 32'(jobs_done), 32'(exp_jobs));
`endif

    // Reset in mid-RUN with two queued jobs.
    stall = 1'b1; lat = 2;
    push_pair(8'd40, 8'd30, 8'd10, 1'b0);
    push_pair(8'd40, 8'd16, 8'd8, 1'b0);
    push_pair(8'd40, 8'd25, 8'd5, 1'b0);
    tick();
    check("t4_running", 32'(unit_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_start", 32'(unit_start), 32'd0);
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    stall = 1'b0;
    repeat (3) tick();
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_jobs_done", 32'(jobs_done), 32'd0);
    check("t4_no_restart", 32'(unit_start), 32'd0);

    // jobs_done wrap after 256 jobs.
    lat = 2;
    for (int i = 0; i < 255; i++) push_pair(8'(i), 8'd0, 8'(i), 1'b0);
    wait_drain();
    check("t6_jobs_255", 32'(jobs_done), 32'd255);
    push_pair(8'd77, 8'd0, 8'd77, 1'b0);
    wait_drain();
    check("t6_jobs_wrap", 32'(jobs_done), 32'd0);
    check("t6_busy_drained", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
    $fatal(1);
  end

endmodule
